pong_game_ctrl: RTL and testbench

Game sequencer for the pong datapath. Derives per-frame move strobes for the paddle and ball blocks from the VGA counters. Runs the serve / play / point / game-over state machine and keeps both players' scores. Sits between the VGA timing generator and the paddle/ball instances; its outputs drive their `move` inputs and the ball's serve hold.

---
 rtl/pong_game_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: derives per-frame move strobes and runs serve/play/point/over, keeping scores.
// Latency: strobes and state update on the pixpulse cycle of the frame tick; strobes stay high one pixel period.
// Optional pause button compiled in with `define PONG_PAUSE_EN (adds pause_btn and the PAUSED state).
module pong_game_ctrl #(
  parameter int MOVE_DIV     = 1,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int GOAL_L       = 8,
  parameter int GOAL_R       = 631,
  parameter int FRAME_LINE   = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       start_btn,
  input  logic [9:0] ball_xloc,
`ifdef PONG_PAUSE_EN
  input  logic       pause_btn,
`endif
  output logic       move_paddle,
  output logic       move_ball,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_POINT  = 3'd3,
    S_OVER   = 3'd4,
    S_PAUSED = 3'd5
  } state_t;

  localparam logic [3:0] DIV_LAST   = 4'(MOVE_DIV - 1);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [9:0] GOAL_L_V   = 10'(GOAL_L);
  localparam logic [9:0] GOAL_R_V   = 10'(GOAL_R);
  localparam logic [9:0] LINE_V     = 10'(FRAME_LINE);

  state_t     state_q, state_d;
  logic       start_s1_q, start_s2_q, start_prev_q, start_prev_d;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic [3:0] div_q, div_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d, winner_q, winner_d;
  logic       move_paddle_q, move_paddle_d, move_ball_q, move_ball_d;
  logic       ball_hold_q, ball_hold_d, game_over_q, game_over_d;
  logic       frame_tick, start_press;
`ifdef PONG_PAUSE_EN
  logic       pause_s1_q, pause_s2_q, pause_prev_q, pause_prev_d;
  logic       pause_press;
  assign pause_prev_d = pixpulse ? pause_s2_q : pause_prev_q;
  assign pause_press  = pixpulse & pause_s2_q & ~pause_prev_q;
`endif

  assign frame_tick   = pixpulse && (hcount == 10'd0) && (vcount == LINE_V);
  assign start_prev_d = pixpulse ? start_s2_q : start_prev_q;
  assign start_press  = pixpulse & start_s2_q & ~start_prev_q;

  // Next-state, score, counter and strobe computation; nothing moves off pixpulse cycles.
  always_comb begin
    state_d       = state_q;
    serve_cnt_d   = serve_cnt_q;
    div_d         = div_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    serve_dir_d   = serve_dir_q;
    winner_d      = winner_q;
    move_paddle_d = move_paddle_q;
    move_ball_d   = move_ball_q;
    ball_hold_d   = ball_hold_q;
    game_over_d   = game_over_q;
    if (pixpulse) begin
      // a strobe set on a tick always drops on the following pixpulse
      move_paddle_d = 1'b0;
      move_ball_d   = 1'b0;
      case (state_q)
        S_IDLE: begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          serve_dir_d = 1'b0;
          if (start_press) begin
            state_d     = S_SERVE;
            serve_cnt_d = 8'd0;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            move_paddle_d = 1'b1;
            if (serve_cnt_q == SERVE_LAST) begin
              state_d     = S_PLAY;
              serve_cnt_d = 8'd0;
              div_d       = 4'd0;
            end else begin
              serve_cnt_d = serve_cnt_q + 8'd1;
            end
          end
        end
        S_PLAY: begin
`ifdef PONG_PAUSE_EN
          if (pause_press) begin
            state_d = S_PAUSED;
          end else
`endif
          if (frame_tick) begin
            move_paddle_d = 1'b1;
            move_ball_d   = (div_q == DIV_LAST);
            div_d         = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
            // left miss wins the tie so a single goal is scored per frame
            if (ball_xloc <= GOAL_L_V) begin
              score_r_d   = score_r_q + 4'd1;
              serve_dir_d = 1'b0;
              state_d     = S_POINT;
            end else if (ball_xloc >= GOAL_R_V) begin
              score_l_d   = score_l_q + 4'd1;
              serve_dir_d = 1'b1;
              state_d     = S_POINT;
            end
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            // serve_dir names the scorer: 1 means the left player just scored
            if ((serve_dir_q ? score_l_q : score_r_q) == WIN) begin
              state_d  = S_OVER;
              winner_d = ~serve_dir_q;
            end else begin
              state_d     = S_SERVE;
              serve_cnt_d = 8'd0;
            end
          end
        end
        S_OVER: begin
          if (start_press) begin
            score_l_d   = 4'd0;
            score_r_d   = 4'd0;
            serve_dir_d = 1'b0;
            serve_cnt_d = 8'd0;
            state_d     = S_SERVE;
          end
        end
`ifdef PONG_PAUSE_EN
        S_PAUSED: begin
          if (pause_press) state_d = S_PLAY;
        end
`endif
        default: state_d = S_IDLE;
      endcase
      ball_hold_d = !((state_d == S_PLAY) || (state_d == S_PAUSED));
      game_over_d = (state_d == S_OVER);
    end
  end

  // All state, synchronizers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      start_s1_q    <= 1'b0;
      start_s2_q    <= 1'b0;
      start_prev_q  <= 1'b0;
      serve_cnt_q   <= 8'd0;
      div_q         <= 4'd0;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      serve_dir_q   <= 1'b0;
      winner_q      <= 1'b0;
      move_paddle_q <= 1'b0;
      move_ball_q   <= 1'b0;
      ball_hold_q   <= 1'b1;
      game_over_q   <= 1'b0;
`ifdef PONG_PAUSE_EN
      pause_s1_q    <= 1'b0;
      pause_s2_q    <= 1'b0;
      pause_prev_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      start_s1_q    <= start_btn;
      start_s2_q    <= start_s1_q;
      start_prev_q  <= start_prev_d;
      serve_cnt_q   <= serve_cnt_d;
      div_q         <= div_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      move_paddle_q <= move_paddle_d;
      move_ball_q   <= move_ball_d;
      ball_hold_q   <= ball_hold_d;
      game_over_q   <= game_over_d;
`ifdef PONG_PAUSE_EN
      pause_s1_q    <= pause_btn;
      pause_s2_q    <= pause_s1_q;
      pause_prev_q  <= pause_prev_d;
`endif
    end
  end

  assign move_paddle = move_paddle_q;
  assign move_ball   = move_ball_q;
  assign ball_hold   = ball_hold_q;
  assign serve_dir   = serve_dir_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign state       = state_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: drives a compressed raster (tick pixel plus random filler pixels per frame),
// random ball positions and button presses, and compares against a game-level model.
module tb_pong_game_ctrl;
  localparam int MOVE_DIV = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE = 7;
  localparam int GOAL_L = 8;
  localparam int GOAL_R = 631;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4, M_PAUSED = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pixpulse = 1'b0;
  logic [9:0] hcount = '0, vcount = '0, ball_xloc = 10'd320;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       move_paddle, move_ball, ball_hold, serve_dir, game_over, winner;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  pong_game_ctrl #(.MOVE_DIV(MOVE_DIV), .SERVE_FRAMES(SERVE_FRAMES), .WIN_SCORE(WIN_SCORE),
                   .GOAL_L(GOAL_L), .GOAL_R(GOAL_R), .FRAME_LINE(480)) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .start_btn(start_btn), .ball_xloc(ball_xloc),
`ifdef PONG_PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .move_paddle(move_paddle), .move_ball(move_ball), .ball_hold(ball_hold),
    .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r), .state(state),
    .game_over(game_over), .winner(winner));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // strobe monitor: index 0 = move_ball, 1 = move_paddle
  int  pulse_cnt [2];
  int  bad_shape = 0;
  int  wid [2];
  int  pps [2];
  logic prev_s [2];

  always @(posedge clk) begin
    logic cur [2];
    #1;
    cur[0] = move_ball;
    cur[1] = move_paddle;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pulse_cnt[i] = 0; prev_s[i] = 1'b0; wid[i] = 0; pps[i] = 0;
      end else begin
        if (!prev_s[i] && cur[i]) begin
          // must rise on the frame-tick pixpulse edge
          if (!(pixpulse && hcount == 10'd0 && vcount == 10'd480)) bad_shape++;
          wid[i] = 1; pps[i] = 0;
        end else if (prev_s[i] && cur[i]) begin
          wid[i]++;
          if (pixpulse) pps[i]++;
        end else if (prev_s[i] && !cur[i]) begin
          if (pixpulse) pps[i]++;
          if (wid[i] != 4 || pps[i] != 1) bad_shape++;
          pulse_cnt[i]++;
        end
        prev_s[i] = cur[i];
      end
    end
  end

  // game-level reference model
  int m_state = M_IDLE, m_sl = 0, m_sr = 0, m_dir = 0, m_win = 0;
  int m_serve = 0, m_play = 0, exp_mb = 0, exp_mp = 0;

  task automatic model_reset();
    m_state = M_IDLE; m_sl = 0; m_sr = 0; m_dir = 0; m_win = 0;
    m_serve = 0; m_play = 0; exp_mb = 0; exp_mp = 0;
  endtask

  task automatic model_tick(input int x);
    case (m_state)
      M_SERVE: begin
        exp_mp++;
        m_serve++;
        if (m_serve == SERVE_FRAMES) begin m_state = M_PLAY; m_play = 0; end
      end
      M_PLAY: begin
        exp_mp++;
        if ((m_play % MOVE_DIV) == MOVE_DIV - 1) exp_mb++;
        m_play++;
        if (x <= GOAL_L) begin m_sr++; m_dir = 0; m_state = M_POINT; end
        else if (x >= GOAL_R) begin m_sl++; m_dir = 1; m_state = M_POINT; end
      end
      M_POINT: begin
        if ((m_dir ? m_sl : m_sr) == WIN_SCORE) begin m_state = M_OVER; m_win = m_dir ? 0 : 1; end
        else begin m_state = M_SERVE; m_serve = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic model_start();
    if (m_state == M_IDLE || m_state == M_OVER) begin
      m_state = M_SERVE; m_sl = 0; m_sr = 0; m_dir = 0; m_serve = 0;
    end
  endtask

  task automatic model_pause();
    if (m_state == M_PLAY) m_state = M_PAUSED;
    else if (m_state == M_PAUSED) m_state = M_PLAY;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, 32'(state), 32'(m_state));
    check({tag, ".score_l"}, 32'(score_l), 32'(m_sl));
    check({tag, ".score_r"}, 32'(score_r), 32'(m_sr));
    check({tag, ".serve_dir"}, 32'(serve_dir), 32'(m_dir));
    check({tag, ".ball_hold"}, 32'(ball_hold), (m_state == M_PLAY || m_state == M_PAUSED) ? 0 : 1);
    check({tag, ".game_over"}, 32'(game_over), (m_state == M_OVER) ? 1 : 0);
    if (m_state == M_OVER) check({tag, ".winner"}, 32'(winner), 32'(m_win));
    check({tag, ".move_ball_pulses"}, 32'(pulse_cnt[0]), 32'(exp_mb));
    check({tag, ".move_paddle_pulses"}, 32'(pulse_cnt[1]), 32'(exp_mp));
    check({tag, ".strobe_shape_errs"}, 32'(bad_shape), 0);
  endtask

  // one pixel period: pixpulse high across exactly one posedge, 4 clk long
  task automatic pix(input int h, input int v);
    @(negedge clk); hcount = 10'(h); vcount = 10'(v); pixpulse = 1'b1;
    @(negedge clk); pixpulse = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic filler();
    if ($urandom_range(0, 3) == 0) pix(0, 481);
    else pix($urandom_range(1, 639), $urandom_range(0, 524));
  endtask

  task automatic frame(input int x);
    ball_xloc = 10'(x);
    pix(0, 480);
    model_tick(x);
    repeat ($urandom_range(3, 5)) filler();
  endtask

  function automatic int safe_x();
    return $urandom_range(GOAL_R - 1, GOAL_L + 1);
  endfunction

  task automatic press_start();
    start_btn = 1'b1; repeat (10) filler();
    start_btn = 1'b0; repeat (4) filler();
    model_start();
  endtask

  task automatic press_pause();
    pause_btn = 1'b1; repeat (10) filler();
    pause_btn = 1'b0; repeat (4) filler();
    model_pause();
  endtask

  initial begin
    bit found;
    int x;
    model_reset();
    repeat (5) @(negedge clk);
    check_model("reset");
    rst = 1'b0;

    repeat (2) frame(safe_x());
    check_model("idle_frames");

    press_start();
    check_model("start_serve");
    repeat (SERVE_FRAMES - 1) frame(safe_x());
    check_model("serve_59");
    frame(safe_x());
    check_model("enter_play");
    repeat (6) frame(safe_x());
    check_model("play_div");

    press_start();
    check_model("start_in_play_ignored");

    frame(5);
    check_model("goal_left_miss");
    frame(safe_x());
    check_model("point_to_serve");
    repeat (SERVE_FRAMES) frame(safe_x());
    check_model("serve_to_play2");
    frame(635);
    check_model("goal_right_miss");

    for (int r = 0; r < 20 && m_sl < 6; r++) begin
      frame(safe_x());
      repeat (SERVE_FRAMES) frame(safe_x());
      repeat ($urandom_range(0, 2)) frame(safe_x());
      if (m_sr < 5 && $urandom_range(0, 1) == 1) x = $urandom_range(0, GOAL_L);
      else x = $urandom_range(GOAL_R, 1023);
      frame(x);
      check_model("rally");
    end
    check("score_l_six", 32'(score_l), 6);

    frame(safe_x());
    repeat (SERVE_FRAMES) frame(safe_x());
    frame(640);
    check_model("winning_point");
    frame(640);
    check_model("game_over");
    repeat (2) frame(640);
    check_model("over_frozen");
    press_start();
    check_model("restart");

    repeat (SERVE_FRAMES) frame(safe_x());
    frame(3);
    frame(safe_x());
    repeat (SERVE_FRAMES) frame(safe_x());
    check_model("before_rst");
    found = 1'b0;
    for (int k = 0; k < MOVE_DIV + 1 && !found; k++) begin
      ball_xloc = 10'd300;
      pix(0, 480);
      model_tick(300);
      if (move_ball === 1'b1) found = 1'b1;
      else repeat (3) filler();
    end
    check("strobe_seen_before_rst", 32'(found), 1);
    rst = 1'b1;
    #1;
    check("async_rst.move_ball", 32'(move_ball), 0);
    check("async_rst.move_paddle", 32'(move_paddle), 0);
    check("async_rst.state", 32'(state), 0);
    check("async_rst.score_r", 32'(score_r), 0);
    check("async_rst.ball_hold", 32'(ball_hold), 1);
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_model("after_rst");

`ifdef PONG_PAUSE_EN
    press_start();
    repeat (SERVE_FRAMES) frame(safe_x());
    frame(safe_x());
    press_pause();
    check_model("paused");
    repeat (5) frame(0);
    check_model("paused_no_strobe_no_goal");
    press_pause();
    check_model("resumed");
    frame(safe_x());
    check_model("resume_f1");
    frame(safe_x());
    check_model("resume_f2");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
